// File: rtl/gray_dec_pkg.sv
// Shared types and helpers for the excess-N Gray decoder: FSM state encoding,
// width-generic Gray/binary conversion and a popcount for the jump check.
package gray_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Helpers work on 32-bit zero-extended values; zero upper bits do not alter
  // a Gray prefix XOR, so callers of any narrower width can cast in and out.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary converter: each binary bit is the XOR of
// the Gray bits at and above it.
module gray2bin_comb #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] i_gray,
  output logic [GW-1:0] o_bin
);

  // Each output bit reduces the shifted input directly, so the loop never
  // reads back its own output vector.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < GW; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_dec_decoder_reg.sv
// Registered, debounced excess-N Gray to one-hot decimal decoder.
// Optional direction outputs (DIR_UP, DIR_STEP) are built when GRAY_DEC_DIR_EN is defined.
module gray_dec_decoder_reg
  import gray_dec_pkg::*;
#(
  parameter int GW         = 4,
  parameter int NOUT       = 10,
  parameter int CODE_OFS   = 3,
  parameter int STABLE_CYC = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [GW-1:0]           GRAY,
  input  logic                    IN_VALID,
  input  logic                    ERR_CLR,
  output logic [NOUT-1:0]         Y_N,
  output logic [$clog2(NOUT)-1:0] DIGIT,
  output logic                    OUT_VALID,
  output logic                    LOCK,
  output logic                    ERR,
`ifdef GRAY_DEC_DIR_EN
  output logic                    DIR_UP,
  output logic                    DIR_STEP,
`endif
  output logic [1:0]              DBG_STATE
);

  localparam int DW = $clog2(NOUT);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYC);

  // Handshake: GRAY is only looked at on rising edges where IN_VALID=1; with
  // IN_VALID=0 candidate and counter hold. OUT_VALID is a single-cycle pulse
  // with no back-pressure, aligned with the edge that updates Y_N/DIGIT.

  state_e            r_state;
  state_e            w_state_nxt;
  logic [GW-1:0]     r_cand;
  logic [CW-1:0]     r_cnt;
  logic [GW-1:0]     r_code;
  logic              r_committed;
  logic [NOUT-1:0]   r_y_n;
  logic [DW-1:0]     r_digit;
  logic              r_out_valid;
  logic              r_err;

  logic [GW-1:0]     w_cand_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [GW-1:0]     w_bin;
  logic [DW-1:0]     w_dig;
  logic              w_in_range;
  logic              w_stable;
  logic              w_new;
  logic              w_commit;
  logic              w_range_err;
  logic              w_jump;

  // Decisions are taken on the candidate/count as they will be after this
  // edge, which gives commit at edge k+STABLE_CYC-1 for a code first seen at k.
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (IN_VALID) begin
      w_cand_nxt = GRAY;
      if (GRAY == r_cand) begin
        w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
      end else begin
        w_cnt_nxt = CW'(1);
      end
    end
  end

  gray2bin_comb #(.GW(GW)) u_gray2bin (
    .i_gray (w_cand_nxt),
    .o_bin  (w_bin)
  );

  assign w_in_range  = (int'(w_bin) >= CODE_OFS) && (int'(w_bin) < CODE_OFS + NOUT);
  assign w_dig       = DW'(w_bin - GW'(CODE_OFS));
  assign w_stable    = IN_VALID && (w_cnt_nxt == CNT_SAT);
  assign w_new       = !r_committed || (w_cand_nxt != r_code);
  assign w_commit    = w_stable && w_in_range && w_new;
  assign w_range_err = w_stable && !w_in_range;
  assign w_jump      = w_commit && r_committed &&
                       (popcount(32'(w_cand_nxt ^ r_code)) > 1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (IN_VALID) w_state_nxt = w_commit ? LOCKED : SETTLE;
      end
      SETTLE: begin
        if (w_commit) begin
          w_state_nxt = LOCKED;
        end else if (w_stable && r_committed && (w_cand_nxt == r_code)) begin
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_commit) begin
          w_state_nxt = LOCKED;
        end else if (IN_VALID && (GRAY != r_code)) begin
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_code      <= '0;
      r_committed <= 1'b0;
      r_y_n       <= '1;
      r_digit     <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_commit;
      if (w_commit) begin
        r_code      <= w_cand_nxt;
        r_committed <= 1'b1;
        r_digit     <= w_dig;
        r_y_n       <= ~(NOUT'(1) << w_dig);
      end
      // A fresh error outranks a clear on the same edge.
      if (w_range_err || w_jump) begin
        r_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef GRAY_DEC_DIR_EN
  logic r_dir_up;
  logic r_dir_step;
  logic w_up;
  logic w_dn;

  assign w_up = (w_dig == DW'((int'(r_digit) + 1) % NOUT));
  assign w_dn = (w_dig == DW'((int'(r_digit) + NOUT - 1) % NOUT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dir_up   <= 1'b0;
      r_dir_step <= 1'b0;
    end else begin
      r_dir_step <= w_commit && r_committed && (w_up || w_dn);
      if (w_commit && r_committed && (w_up || w_dn)) begin
        r_dir_up <= w_up;
      end
    end
  end

  assign DIR_UP   = r_dir_up;
  assign DIR_STEP = r_dir_step;
`endif

  assign Y_N       = r_y_n;
  assign DIGIT     = r_digit;
  assign OUT_VALID = r_out_valid;
  assign LOCK      = (r_state == LOCKED);
  assign ERR       = r_err;
  assign DBG_STATE = r_state;

endmodule
